// File: rtl/multi_button_debounce_if.sv
// Button-conditioner bus: raw pins and controls in, conditioned level/pulse/count out.
interface multi_button_debounce_if #(
    parameter int N     = 2,
    parameter int CNT_W = 8
);
    logic [N-1:0]       btn_in;
    logic [1:0]         edge_sel;
    logic               clr_count;
    logic [N-1:0]       level;
    logic [N-1:0]       pulse;
    logic               pulse_any;
    logic [N*CNT_W-1:0] count;

    modport master (
        output btn_in, edge_sel, clr_count,
        input  level, pulse, pulse_any, count
    );

    modport slave (
        input  btn_in, edge_sel, clr_count,
        output level, pulse, pulse_any, count
    );
endinterface

// File: rtl/multi_button_debounce.sv
// N-channel button conditioner: synchroniser, per-channel debounce FSM,
// selectable one-cycle edge pulse and a wrapping event counter per channel.
module mbd_lane #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter bit ACTIVE_LOW      = 1'b0,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pin,
    input  logic [1:0]       edge_sel,
    input  logic             clr_count,
    output logic             level,
    output logic             pulse,
    output logic [CNT_W-1:0] count
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] LAST = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO} st_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    st_t                    state, state_nxt;
    logic [DW-1:0]          cnt, cnt_nxt;
    logic                   lvl_nxt, rise, fall, sel_rise, sel_fall;

    // Polarity is folded in before the first flop so everything after is active-high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], pin ^ ACTIVE_LOW};
    end
    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE_LO;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            level <= lvl_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        lvl_nxt   = level;
        rise      = 1'b0;
        fall      = 1'b0;
        case (state)
            IDLE_LO: if (sync) begin
                state_nxt = WAIT_HI;
                cnt_nxt   = DW'(1);
            end
            WAIT_HI: if (!sync) begin
                state_nxt = IDLE_LO;
                cnt_nxt   = '0;
            end else if (cnt == LAST) begin
                state_nxt = IDLE_HI;
                cnt_nxt   = '0;
                lvl_nxt   = 1'b1;
                rise      = 1'b1;
            end else begin
                cnt_nxt   = cnt + DW'(1);
            end
            IDLE_HI: if (!sync) begin
                state_nxt = WAIT_LO;
                cnt_nxt   = DW'(1);
            end
            WAIT_LO: if (sync) begin
                state_nxt = IDLE_HI;
                cnt_nxt   = '0;
            end else if (cnt == LAST) begin
                state_nxt = IDLE_LO;
                cnt_nxt   = '0;
                lvl_nxt   = 1'b0;
                fall      = 1'b1;
            end else begin
                cnt_nxt   = cnt + DW'(1);
            end
            default: state_nxt = IDLE_LO;
        endcase
    end

    assign sel_rise = (edge_sel == 2'b00) || (edge_sel == 2'b10);
    assign sel_fall = (edge_sel == 2'b01) || (edge_sel == 2'b10);

    // Pulse registers on the same edge as level; the clear wins over a same-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse <= 1'b0;
            count <= '0;
        end else begin
            pulse <= (rise & sel_rise) | (fall & sel_fall);
            if (clr_count)  count <= '0;
            else if (pulse) count <= count + CNT_W'(1);
        end
    end
endmodule

module multi_button_debounce #(
    parameter int N               = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter bit ACTIVE_LOW      = 1'b0,
    parameter int CNT_W           = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    multi_button_debounce_if.slave  bus
);
    logic [N-1:0][CNT_W-1:0] cnt;
    logic [N-1:0]            lvl, pul;

    for (genvar i = 0; i < N; i++) begin : g_lane
        mbd_lane #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW),
            .CNT_W          (CNT_W)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .pin      (bus.btn_in[i]),
            .edge_sel (bus.edge_sel),
            .clr_count(bus.clr_count),
            .level    (lvl[i]),
            .pulse    (pul[i]),
            .count    (cnt[i])
        );
    end

    assign bus.level     = lvl;
    assign bus.pulse     = pul;
    assign bus.pulse_any = |pul;
    assign bus.count     = cnt;
endmodule

// File: tb/tb_multi_button_debounce.sv
// Directed bench: expected pulses queued at stimulus time, checked by a negedge monitor.
module tb_multi_button_debounce;
    localparam int N = 2, CNT_W = 3, D = 4, SS = 2, LAT = SS + D;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    multi_button_debounce_if #(.N(N), .CNT_W(CNT_W)) a ();
    multi_button_debounce_if #(.N(N), .CNT_W(CNT_W)) b ();

    multi_button_debounce #(.N(N), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(D),
                            .ACTIVE_LOW(1'b0), .CNT_W(CNT_W))
        u_dut_a (.clk(clk), .rst_n(rst_n), .bus(a));
    multi_button_debounce #(.N(N), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(D),
                            .ACTIVE_LOW(1'b1), .CNT_W(CNT_W))
        u_dut_b (.clk(clk), .rst_n(rst_n), .bus(b));

    typedef struct { int ch; int cyc; } ev_t;
    ev_t sb[$];
    ev_t e;
    logic [3:0] pul;
    int vec = 0, miss = 0;
    int k, r;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int ch, input int at);
        ev_t ev;
        ev.ch = ch; ev.cyc = at;
        sb.push_back(ev);
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) begin @(posedge clk); #1; end
    endtask

    // Channels 0/1 are DUT a, 2/3 are DUT b (active-low pins).
    always @(negedge clk) begin
        pul = {b.pulse, a.pulse};
        for (int c = 0; c < 4; c++) begin
            if (pul[c]) begin
                chk("pulse_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("pulse_ch", c, e.ch);
                    chk("pulse_cyc", cyc, e.cyc);
                    chk("pulse_any", (c < 2) ? a.pulse_any : b.pulse_any, 1);
                end
            end
        end
    end

    initial begin
        a.btn_in = '0; a.edge_sel = 2'b00; a.clr_count = 1'b0;
        b.btn_in = 2'b11; b.edge_sel = 2'b00; b.clr_count = 1'b0;

        // Reset state
        step(3);
        chk("rst_level", a.level, 0);
        chk("rst_pulse", a.pulse, 0);
        chk("rst_pulse_any", a.pulse_any, 0);
        chk("rst_count", a.count, 0);
        chk("rst_b_level", b.level, 0);
        chk("rst_b_count", b.count, 0);
        rst_n = 1'b1;
        step(3);

        // Clean press ch0
        k = cyc; a.btn_in = 2'b01; push(0, k + LAT);
        wait_to(k + LAT - 1); chk("press_early", a.level, 2'b00);
        wait_to(k + LAT);     chk("press_level", a.level, 2'b01);
        wait_to(k + LAT + 1);
        chk("press_count0", a.count[2:0], 1);
        chk("press_count1", a.count[5:3], 0);
        a.btn_in = 2'b00; step(LAT + 4);
        chk("release_level", a.level, 0);
        chk("release_count0", a.count[2:0], 1);

        // Bounce then hold
        a.btn_in = 2'b01; step(2); a.btn_in = 2'b00; step(2);
        a.btn_in = 2'b01; step(2); a.btn_in = 2'b00; step(2);
        k = cyc; a.btn_in = 2'b01; push(0, k + LAT);
        wait_to(k + LAT - 1); chk("bounce_early", a.level, 0);
        wait_to(k + LAT + 1);
        chk("bounce_level", a.level, 2'b01);
        chk("bounce_count0", a.count[2:0], 2);
        a.btn_in = 2'b00; step(LAT + 2);

        // Mode sweep on ch1
        a.clr_count = 1'b1; step(1); a.clr_count = 1'b0;
        chk("clr_count", a.count, 0);
        a.edge_sel = 2'b01;
        a.btn_in = 2'b10; step(LAT + 2);
        chk("m01_level", a.level, 2'b10);
        k = cyc; a.btn_in = 2'b00; push(1, k + LAT);
        wait_to(k + LAT + 1);
        chk("m01_count1", a.count[5:3], 1);
        chk("m01_level_lo", a.level, 0);

        a.clr_count = 1'b1; step(1); a.clr_count = 1'b0;
        a.edge_sel = 2'b10;
        k = cyc; a.btn_in = 2'b10; push(1, k + LAT); step(LAT + 2);
        k = cyc; a.btn_in = 2'b00; push(1, k + LAT); step(LAT + 2);
        chk("m10_count1", a.count[5:3], 2);

        a.edge_sel = 2'b11;
        a.btn_in = 2'b10; step(LAT + 2);
        chk("m11_level", a.level, 2'b10);
        a.btn_in = 2'b00; step(LAT + 2);
        chk("m11_count1", a.count[5:3], 2);

        // Wrap and clear on ch0
        a.edge_sel = 2'b00;
        a.clr_count = 1'b1; step(1); a.clr_count = 1'b0;
        for (int i = 0; i < 9; i++) begin
            k = cyc; a.btn_in = 2'b01; push(0, k + LAT); step(LAT + 2);
            a.btn_in = 2'b00; step(LAT + 2);
        end
        chk("wrap_count0", a.count[2:0], 1);
        k = cyc; a.btn_in = 2'b01; push(0, k + LAT);
        wait_to(k + LAT); a.clr_count = 1'b1;
        wait_to(k + LAT + 1); a.clr_count = 1'b0;
        chk("clr_vs_pulse", a.count[2:0], 0);
        a.btn_in = 2'b00; step(LAT + 2);

        // Reset mid-debounce with both buttons held
        k = cyc; a.btn_in = 2'b10; push(1, k + LAT); step(LAT + 2);
        chk("pre_rst_level", a.level, 2'b10);
        chk("pre_rst_count1", a.count[5:3], 1);
        k = cyc; a.btn_in = 2'b11;
        wait_to(k + 4);
        rst_n = 1'b0; #1;
        chk("midrst_level", a.level, 0);
        chk("midrst_pulse", a.pulse, 0);
        chk("midrst_pulse_any", a.pulse_any, 0);
        chk("midrst_count", a.count, 0);
        step(2);
        r = cyc; rst_n = 1'b1;
        push(0, r + LAT); push(1, r + LAT);
        wait_to(r + LAT - 1); chk("postrst_early", a.level, 0);
        wait_to(r + LAT + 1);
        chk("postrst_level", a.level, 2'b11);
        chk("postrst_count", a.count, 6'b001_001);
        a.btn_in = 2'b00; step(LAT + 2);

        // Active-low variant
        chk("al_idle_level", b.level, 0);
        k = cyc; b.btn_in = 2'b10; push(2, k + LAT);
        wait_to(k + LAT - 1); chk("al_early", b.level, 0);
        wait_to(k + LAT + 1);
        chk("al_level", b.level, 2'b01);
        chk("al_count", b.count, 6'b000_001);
        b.btn_in = 2'b11; step(LAT + 4);
        chk("al_release", b.level, 0);

        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
